// File: rtl/awsr_pkg.sv
// Shared radar-datapath definitions: pulse sequencer state encoding,
// bus widths and clock-derived cycle limits.
package awsr_pkg;

    // Pulse sequencer control states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PPS = 2'd1,
        RUN      = 2'd2
    } pseq_state_t;

    localparam int PSEQ_ADDR_W = 32'd14;
    localparam int PSEQ_PRI_W  = 32'd24;
    localparam int PSEQ_CNT_W  = 32'd16;

    // ref_clk frequency and a 10 us bound for PPS-related waits.
    localparam int unsigned CLKF               = 32'd215_040_000;
    localparam int unsigned PSEQ_PPS_LIMIT_CYC = CLKF / 32'd100_000;

endpackage

// File: rtl/pulse_sequencer.sv
// Transmit pulse scheduler: after arm, plays the waveform memory a set number
// of times at a fixed PRI, driving the DAC address and TX/RX gates.
// Optional PPS alignment of the first pulse is built when the macro
// PULSE_SEQUENCER_PPS_EN is defined; otherwise start_on_pps and pps are ignored.
module pulse_sequencer
    import awsr_pkg::*;
#(
    parameter int ADDR_W = PSEQ_ADDR_W,
    parameter int PRI_W  = PSEQ_PRI_W,
    parameter int CNT_W  = PSEQ_CNT_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              arm,
    input  logic              start_on_pps,
    input  logic              pps,
    input  logic [ADDR_W-1:0] cfg_wave_len,
    input  logic [PRI_W-1:0]  cfg_pri,
    input  logic [CNT_W-1:0]  cfg_npulses,
    output logic [ADDR_W-1:0] dac_addr,
    output logic              tx_gate,
    output logic              rx_gate,
    output logic              pulse_start,
    output logic [CNT_W-1:0]  pulse_idx,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [PRI_W-1:0] PRI_ONE = {{(PRI_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pseq_state_t       state_r, state_s;
    logic [PRI_W-1:0]  pri_cnt_r, pri_cnt_s;
    logic [ADDR_W-1:0] wave_len_r, wave_len_s;
    logic [PRI_W-1:0]  pri_eff_r, pri_eff_s;
    logic [CNT_W-1:0]  npulses_r, npulses_s;
    logic [CNT_W-1:0]  pulse_idx_s;
    logic              arm_block_r, arm_block_s;
    logic [PRI_W-1:0]  cfg_wave_ext_s;
    logic [PRI_W-1:0]  cfg_pri_eff_s;
    logic [PRI_W-1:0]  run_wave_ext_s;
    logic              last_pulse_s;
    logic [ADDR_W-1:0] dac_addr_s;
    logic              tx_gate_s;
    logic              rx_gate_s;
    logic              pulse_start_s;
    logic              busy_s;
    logic              done_s;
    logic              cfg_err_s;

`ifndef PULSE_SEQUENCER_PPS_EN
    // PPS inputs stay on the port list but have no function in this build.
    logic unused_pps_s;
    assign unused_pps_s = start_on_pps ^ pps;
`endif

    // Next-state, counter and next-output computation for the sequencer.
    always_comb begin
        state_s        = state_r;
        pri_cnt_s      = pri_cnt_r;
        wave_len_s     = wave_len_r;
        pri_eff_s      = pri_eff_r;
        npulses_s      = npulses_r;
        pulse_idx_s    = pulse_idx;
        done_s         = 1'b0;
        cfg_err_s      = 1'b0;
        // A rejected or completed arm must be released before it counts again.
        if (!arm) begin
            arm_block_s = 1'b0;
        end else begin
            arm_block_s = arm_block_r;
        end

        // The clamp keeps at least one listen cycle in every PRI.
        cfg_wave_ext_s = {{(PRI_W-ADDR_W){1'b0}}, cfg_wave_len};
        if (cfg_pri > cfg_wave_ext_s) begin
            cfg_pri_eff_s = cfg_pri;
        end else begin
            cfg_pri_eff_s = cfg_wave_ext_s + PRI_ONE;
        end
        last_pulse_s = (npulses_r != {CNT_W{1'b0}}) && (pulse_idx == (npulses_r - CNT_ONE));

        case (state_r)
            IDLE: begin
                if (!arm || arm_block_r) begin
                    state_s = IDLE;
                end else if (cfg_wave_len == {ADDR_W{1'b0}}) begin
                    cfg_err_s   = 1'b1;
                    arm_block_s = 1'b1;
                end else begin
                    wave_len_s = cfg_wave_len;
                    pri_eff_s  = cfg_pri_eff_s;
                    npulses_s  = cfg_npulses;
`ifdef PULSE_SEQUENCER_PPS_EN
                    if (start_on_pps) begin
                        state_s = WAIT_PPS;
                    end else begin
                        state_s     = RUN;
                        pri_cnt_s   = {PRI_W{1'b0}};
                        pulse_idx_s = {CNT_W{1'b0}};
                    end
`else
                    state_s     = RUN;
                    pri_cnt_s   = {PRI_W{1'b0}};
                    pulse_idx_s = {CNT_W{1'b0}};
`endif
                end
            end
            WAIT_PPS: begin
`ifdef PULSE_SEQUENCER_PPS_EN
                if (!arm) begin
                    state_s = IDLE;
                end else if (pps) begin
                    state_s     = RUN;
                    pri_cnt_s   = {PRI_W{1'b0}};
                    pulse_idx_s = {CNT_W{1'b0}};
                end else begin
                    state_s = WAIT_PPS;
                end
`else
                state_s = IDLE;
`endif
            end
            RUN: begin
                if (pri_cnt_r == (pri_eff_r - PRI_ONE)) begin
                    if (last_pulse_s || !arm) begin
                        state_s     = IDLE;
                        done_s      = 1'b1;
                        pri_cnt_s   = {PRI_W{1'b0}};
                        arm_block_s = arm;
                    end else begin
                        pri_cnt_s   = {PRI_W{1'b0}};
                        pulse_idx_s = pulse_idx + CNT_ONE;
                    end
                end else begin
                    pri_cnt_s = pri_cnt_r + PRI_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Outputs are derived from the next counter value so they can be registered.
        run_wave_ext_s = {{(PRI_W-ADDR_W){1'b0}}, wave_len_s};
        if (state_s == RUN) begin
            tx_gate_s     = (pri_cnt_s < run_wave_ext_s);
            rx_gate_s     = !tx_gate_s;
            pulse_start_s = (pri_cnt_s == {PRI_W{1'b0}});
            if (tx_gate_s) begin
                dac_addr_s = pri_cnt_s[ADDR_W-1:0];
            end else begin
                dac_addr_s = {ADDR_W{1'b0}};
            end
        end else begin
            tx_gate_s     = 1'b0;
            rx_gate_s     = 1'b0;
            pulse_start_s = 1'b0;
            dac_addr_s    = {ADDR_W{1'b0}};
        end
        busy_s = (state_s != IDLE);
    end

    // State, latched configuration, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r     <= IDLE;
            pri_cnt_r   <= {PRI_W{1'b0}};
            wave_len_r  <= {ADDR_W{1'b0}};
            pri_eff_r   <= {PRI_W{1'b0}};
            npulses_r   <= {CNT_W{1'b0}};
            arm_block_r <= 1'b0;
            pulse_idx   <= {CNT_W{1'b0}};
            dac_addr    <= {ADDR_W{1'b0}};
            tx_gate     <= 1'b0;
            rx_gate     <= 1'b0;
            pulse_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state_r     <= state_s;
            pri_cnt_r   <= pri_cnt_s;
            wave_len_r  <= wave_len_s;
            pri_eff_r   <= pri_eff_s;
            npulses_r   <= npulses_s;
            arm_block_r <= arm_block_s;
            pulse_idx   <= pulse_idx_s;
            dac_addr    <= dac_addr_s;
            tx_gate     <= tx_gate_s;
            rx_gate     <= rx_gate_s;
            pulse_start <= pulse_start_s;
            busy        <= busy_s;
            done        <= done_s;
            cfg_err     <= cfg_err_s;
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: table-driven finite runs plus
// hand-written sequences for stop, invalid config, reset and PPS start.
module tb_pulse_sequencer;
    import awsr_pkg::*;

    logic        clk = 1'b0;
    logic        srst;
    logic        arm;
    logic        start_on_pps;
    logic        pps;
    logic [13:0] cfg_wave_len;
    logic [23:0] cfg_pri;
    logic [15:0] cfg_npulses;
    logic [13:0] dac_addr;
    logic        tx_gate;
    logic        rx_gate;
    logic        pulse_start;
    logic [15:0] pulse_idx;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [13:0] wave_len;
        logic [23:0] pri;
        logic [15:0] npulses;
        int          exp_pri;
        int          exp_done;
    } run_vec_t;

    run_vec_t vecs [4];

    always #5 clk = ~clk;

    pulse_sequencer dut (
        .clk          (clk),
        .srst         (srst),
        .arm          (arm),
        .start_on_pps (start_on_pps),
        .pps          (pps),
        .cfg_wave_len (cfg_wave_len),
        .cfg_pri      (cfg_pri),
        .cfg_npulses  (cfg_npulses),
        .dac_addr     (dac_addr),
        .tx_gate      (tx_gate),
        .rx_gate      (rx_gate),
        .pulse_start  (pulse_start),
        .pulse_idx    (pulse_idx),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int dac, input int tx, input int rx,
                              input int ps, input int idx, input int bsy, input int dn,
                              input int err);
        check({tag, ".dac_addr"}, 32'(dac_addr), dac);
        check({tag, ".tx_gate"}, 32'(tx_gate), tx);
        check({tag, ".rx_gate"}, 32'(rx_gate), rx);
        check({tag, ".pulse_start"}, 32'(pulse_start), ps);
        check({tag, ".pulse_idx"}, 32'(pulse_idx), idx);
        check({tag, ".busy"}, 32'(busy), bsy);
        check({tag, ".done"}, 32'(done), dn);
        check({tag, ".cfg_err"}, 32'(cfg_err), err);
    endtask

    initial begin
        vecs[0] = '{wave_len: 14'd4, pri: 24'd10, npulses: 16'd3, exp_pri: 10, exp_done: 31};
        vecs[1] = '{wave_len: 14'd8, pri: 24'd5,  npulses: 16'd2, exp_pri: 9,  exp_done: 19};
        vecs[2] = '{wave_len: 14'd3, pri: 24'd3,  npulses: 16'd1, exp_pri: 4,  exp_done: 5};
        vecs[3] = '{wave_len: 14'd1, pri: 24'd2,  npulses: 16'd2, exp_pri: 2,  exp_done: 5};

        srst = 1'b1; arm = 1'b0; start_on_pps = 1'b0; pps = 1'b0;
        cfg_wave_len = 14'd4; cfg_pri = 24'd10; cfg_npulses = 16'd3;
        step();
        step();
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        srst = 1'b0;
        step();
        check_outs("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Finite runs with hand-computed PRI (clamped where needed) and done cycle.
        for (int v = 0; v < 4; v++) begin
            cfg_wave_len = vecs[v].wave_len;
            cfg_pri      = vecs[v].pri;
            cfg_npulses  = vecs[v].npulses;
            arm = 1'b1;
            for (int k = 1; k <= vecs[v].exp_done; k++) begin
                step();
                if (k == 2) begin
                    // Mid-run config changes must not take effect.
                    cfg_wave_len = 14'd1; cfg_pri = 24'd3; cfg_npulses = 16'd0;
                end
                if (k < vecs[v].exp_done) begin
                    int c;
                    int t;
                    c = (k - 1) % vecs[v].exp_pri;
                    t = (c < int'(vecs[v].wave_len)) ? 1 : 0;
                    check_outs($sformatf("vec%0d.k%0d", v, k), t ? c : 0, t, 1 - t,
                               (c == 0) ? 1 : 0, (k - 1) / vecs[v].exp_pri, 1, 0, 0);
                end else begin
                    check_outs($sformatf("vec%0d.done", v), 0, 0, 0, 0,
                               int'(vecs[v].npulses) - 1, 0, 1, 0);
                end
            end
            arm = 1'b0;
            step();
            check(.name($sformatf("vec%0d.done_strobe", v)), .act(32'(done)), .exp(32'd0));
            step();
        end

        // Graceful stop of a continuous run: arm drops in the third pulse.
        cfg_wave_len = 14'd4; cfg_pri = 24'd20; cfg_npulses = 16'd0;
        arm = 1'b1;
        for (int k = 1; k <= 61; k++) begin
            step();
            if (k == 42) arm = 1'b0;
            if (k < 61) begin
                check($sformatf("stop.k%0d.pulse_start", k), 32'(pulse_start),
                      ((k - 1) % 20 == 0) ? 32'd1 : 32'd0);
                check($sformatf("stop.k%0d.done", k), 32'(done), 32'd0);
                check($sformatf("stop.k%0d.pulse_idx", k), 32'(pulse_idx), 32'((k - 1) / 20));
            end else begin
                check_outs("stop.done", 0, 0, 0, 0, 2, 0, 1, 0);
            end
        end
        for (int k = 0; k < 25; k++) begin
            step();
            check($sformatf("stop.after%0d.pulse_start", k), 32'(pulse_start), 32'd0);
        end

        // Invalid config: single cfg_err strobe, no rearm while arm stays high.
        cfg_wave_len = 14'd0;
        arm = 1'b1;
        step();
        check_outs("err.strobe", 0, 0, 0, 0, 2, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("err.hold%0d.cfg_err", k), 32'(cfg_err), 32'd0);
            check($sformatf("err.hold%0d.busy", k), 32'(busy), 32'd0);
        end
        cfg_wave_len = 14'd4; cfg_pri = 24'd10;
        step();
        check(.name("err.blocked.busy"), .act(32'(busy)), .exp(32'd0));
        arm = 1'b0;
        step();
        arm = 1'b1;

        // Reset mid-pulse once dac_addr reaches 2.
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("rst.k%0d.dac_addr", k), 32'(dac_addr), 32'(k - 1));
        end
        srst = 1'b1;
        step();
        check_outs("rst.mid", 0, 0, 0, 0, 0, 0, 0, 0);
        arm = 1'b0;
        step();
        check(.name("rst.no_done"), .act(32'(done)), .exp(32'd0));
        srst = 1'b0;
        step();

`ifdef PULSE_SEQUENCER_PPS_EN
        // PPS-aligned start; pps in IDLE (alone or with arm) is ignored.
        begin
            int w;
            start_on_pps = 1'b1;
            cfg_wave_len = 14'd4; cfg_pri = 24'd10; cfg_npulses = 16'd1;
            pps = 1'b1;
            step();
            pps = 1'b0;
            check_outs("pps.idle", 0, 0, 0, 0, 0, 0, 0, 0);
            arm = 1'b1; pps = 1'b1;
            step();
            pps = 1'b0;
            check_outs("pps.wait", 0, 0, 0, 0, 0, 1, 0, 0);
            for (int k = 0; k < 3; k++) begin
                step();
                check($sformatf("pps.wait%0d.pulse_start", k), 32'(pulse_start), 32'd0);
            end
            pps = 1'b1;
            step();
            pps = 1'b0;
            w = 0;
            while (!pulse_start && w < int'(PSEQ_PPS_LIMIT_CYC)) begin
                step();
                w++;
            end
            check(.name("pps.latency"), .act(32'(w)), .exp(32'd0));
            check_outs("pps.first", 0, 1, 0, 1, 0, 1, 0, 0);
            for (int k = 2; k <= 11; k++) step();
            check_outs("pps.done", 0, 0, 0, 0, 0, 0, 1, 0);
            arm = 1'b0;
            step();
            arm = 1'b1;
            step();
            check(.name("pps.abort.busy_on"), .act(32'(busy)), .exp(32'd1));
            arm = 1'b0;
            step();
            check(.name("pps.abort.busy_off"), .act(32'(busy)), .exp(32'd0));
            check(.name("pps.abort.done"), .act(32'(done)), .exp(32'd0));
            start_on_pps = 1'b0;
        end
`else
        // Without PPS support start_on_pps is ignored and the run starts at once.
        start_on_pps = 1'b1;
        cfg_wave_len = 14'd4; cfg_pri = 24'd10; cfg_npulses = 16'd0;
        arm = 1'b1;
        step();
        check_outs("nopps.first", 0, 1, 0, 1, 0, 1, 0, 0);
        arm = 1'b0;
        for (int k = 2; k <= 11; k++) step();
        check_outs("nopps.done", 0, 0, 0, 0, 0, 0, 1, 0);
        start_on_pps = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
